// File: rtl/fsa_redundancy_pe_param_pkg.sv
// Shared types and arithmetic for the fault-tolerant systolic array PE.
// Supports accumulator widths up to MAX_ACC_W bits.
package fsa_pkg;

   typedef enum logic [1:0] {
      MODE_PASS   = 2'b00,
      MODE_ACCUM  = 2'b01,
      MODE_BYPASS = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int MAX_ACC_W = 64;

   // Operands arrive sign-extended from acc_w bits. The caller keeps the low
   // acc_w bits, so the unsaturated result wraps modulo 2^acc_w.
   function automatic logic signed [MAX_ACC_W-1:0] sat_add(
      input logic signed [MAX_ACC_W-1:0] a,
      input logic signed [MAX_ACC_W-1:0] b,
      input int                          acc_w,
      input bit                          sat
   );
      logic signed [MAX_ACC_W:0] one, sum, max_v, min_v, res;
      one   = {{MAX_ACC_W{1'b0}}, 1'b1};
      sum   = {a[MAX_ACC_W-1], a} + {b[MAX_ACC_W-1], b};
      max_v = (one << (acc_w - 1)) - one;
      min_v = ~max_v;
      res   = sum;
      if (sat && (sum > max_v)) res = max_v;
      if (sat && (sum < min_v)) res = min_v;
      return res[MAX_ACC_W-1:0];
   endfunction

endpackage

// File: rtl/fsa_redundancy_pe_param_if.sv
// Dataflow bundle between the array fabric and one PE.
// act_valid_in qualifies act_in for one cycle; psum_valid_out qualifies psum_out
// for one cycle. There is no backpressure: the PE accepts every valid beat.
interface fsa_redundancy_pe_param_if #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32
);
   logic [1:0]               mode;
   logic                     begin_repair;
   logic                     weight_en;
   logic signed [DATA_W-1:0] weight_in;
   logic signed [DATA_W-1:0] act_in;
   logic                     act_valid_in;
   logic signed [ACC_W-1:0]  psum_in;
   logic signed [DATA_W-1:0] act_out;
   logic                     act_valid_out;
   logic signed [ACC_W-1:0]  psum_out;
   logic                     psum_valid_out;
   logic                     busy;
   logic                     repaired;

   modport master (
      output mode, begin_repair, weight_en, weight_in, act_in, act_valid_in, psum_in,
      input  act_out, act_valid_out, psum_out, psum_valid_out, busy, repaired
   );

   modport slave (
      input  mode, begin_repair, weight_en, weight_in, act_in, act_valid_in, psum_in,
      output act_out, act_valid_out, psum_out, psum_valid_out, busy, repaired
   );
endinterface

// File: rtl/fsa_redundancy_pe_param_mac_sat.sv
// Combinational signed multiply, sign-extend to ACC_W, then saturating or wrapping add.
module fsa_mac_sat
   import fsa_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32,
   parameter int SAT    = 1
) (
   input  logic signed [DATA_W-1:0] act,
   input  logic signed [DATA_W-1:0] weight,
   input  logic signed [ACC_W-1:0]  addend,
   output logic signed [ACC_W-1:0]  sum
);
   logic signed [2*DATA_W-1:0] product;

   assign product = act * weight;
   assign sum     = ACC_W'(sat_add(MAX_ACC_W'(addend), MAX_ACC_W'(product), ACC_W, SAT != 0));
endmodule

// File: rtl/fsa_redundancy_pe_param.sv
// Systolic-array PE: PASS / ACCUM / BYPASS dataflows with a sticky repair latch
// that forces bypass once the PE has been flagged faulty.
module fsa_redundancy_pe_param
   import fsa_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ACC_W   = 32,
   parameter int ACC_LEN = 8,
   parameter int SAT     = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   fsa_redundancy_pe_param_if.slave      bus,
   output state_t                        dbg_state
);
   localparam int CNT_W = $clog2(ACC_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

   state_t                   state, state_nxt;
   logic signed [DATA_W-1:0] weight;
   logic signed [ACC_W-1:0]  acc, acc_nxt, addend, mac_sum;
   logic [CNT_W-1:0]         cnt, cnt_nxt;
   logic signed [ACC_W-1:0]  psum_q, psum_nxt;
   logic                     pv_q, pv_nxt, repaired_q, beat_last;
   mode_t                    eff_mode;

   assign eff_mode  = repaired_q ? MODE_BYPASS : mode_t'(bus.mode);
   // Only a run already in RUN adds onto acc; a fresh beat starts from zero.
   assign addend    = (eff_mode != MODE_ACCUM) ? bus.psum_in : ((state == ST_RUN) ? acc : '0);
   assign beat_last = (((state == ST_RUN) ? cnt : '0) == LAST_CNT);

   fsa_mac_sat #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SAT(SAT)) u_mac (
      .act    (bus.act_in),
      .weight (weight),
      .addend (addend),
      .sum    (mac_sum)
   );

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      psum_nxt  = psum_q;
      pv_nxt    = 1'b0;
      case (eff_mode)
         MODE_PASS: begin
            state_nxt = ST_IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            if (bus.act_valid_in) begin
               psum_nxt = mac_sum;
               pv_nxt   = 1'b1;
            end
         end
         MODE_BYPASS: begin
            state_nxt = ST_IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            psum_nxt  = bus.psum_in;
            pv_nxt    = bus.act_valid_in;
         end
         MODE_ACCUM: begin
            if (bus.act_valid_in) begin
               acc_nxt = mac_sum;
               cnt_nxt = (state == ST_RUN) ? cnt + CNT_W'(1) : CNT_W'(1);
               if (beat_last) begin
                  state_nxt = ST_DRAIN;
                  psum_nxt  = mac_sum;
                  pv_nxt    = 1'b1;
               end else begin
                  state_nxt = ST_RUN;
               end
            end else if (state != ST_RUN) begin
               // DRAIN with no new beat retires the run; RUN holds on gaps.
               state_nxt = ST_IDLE;
               acc_nxt   = '0;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            psum_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state             <= ST_IDLE;
         weight            <= '0;
         acc               <= '0;
         cnt               <= '0;
         psum_q            <= '0;
         pv_q              <= 1'b0;
         repaired_q        <= 1'b0;
         bus.act_out       <= '0;
         bus.act_valid_out <= 1'b0;
      end else begin
         state             <= state_nxt;
         acc               <= acc_nxt;
         cnt               <= cnt_nxt;
         psum_q            <= psum_nxt;
         pv_q              <= pv_nxt;
         bus.act_out       <= bus.act_in;
         bus.act_valid_out <= bus.act_valid_in;
         if (bus.weight_en)    weight     <= bus.weight_in;
         if (bus.begin_repair) repaired_q <= 1'b1;
      end
   end

   assign bus.psum_out       = psum_q;
   assign bus.psum_valid_out = pv_q;
   assign bus.busy           = (state != ST_IDLE);
   assign bus.repaired       = repaired_q;
   assign dbg_state          = state;
endmodule

// File: tb/tb_fsa_redundancy_pe_param.sv
// Directed bench for fsa_redundancy_pe_param; a second instance with SAT=0
// shares the stimulus so wrap-around can be checked beside saturation.
module tb_fsa_redundancy_pe_param;
   import fsa_pkg::*;

   logic   clk = 1'b0;
   logic   rst = 1'b0;
   int     n_tests = 0;
   int     n_fail  = 0;
   state_t dbg_state, dbg_state0;

   always #5 clk = ~clk;

   fsa_redundancy_pe_param_if #(.DATA_W(16), .ACC_W(32)) bus ();
   fsa_redundancy_pe_param_if #(.DATA_W(16), .ACC_W(32)) bus0 ();

   assign bus0.mode         = bus.mode;
   assign bus0.begin_repair = bus.begin_repair;
   assign bus0.weight_en    = bus.weight_en;
   assign bus0.weight_in    = bus.weight_in;
   assign bus0.act_in       = bus.act_in;
   assign bus0.act_valid_in = bus.act_valid_in;
   assign bus0.psum_in      = bus.psum_in;

   fsa_redundancy_pe_param #(.DATA_W(16), .ACC_W(32), .ACC_LEN(8), .SAT(1)) dut (
      .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
   );
   fsa_redundancy_pe_param #(.DATA_W(16), .ACC_W(32), .ACC_LEN(8), .SAT(0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg_state0)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input mode_t m, input logic v, input int a, input logic [31:0] p);
      bus.mode         = m;
      bus.act_valid_in = v;
      bus.act_in       = 16'(a);
      bus.psum_in      = p;
   endtask

   task automatic load_weight(input int w);
      bus.weight_en    = 1'b1;
      bus.weight_in    = 16'(w);
      bus.act_valid_in = 1'b0;
      step();
      bus.weight_en    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(MODE_PASS, 1'b1, 3, 32'd9);
      step();
      step();
      n_tests++; if (bus.psum_out !== 32'd0) begin n_fail++; $display("FAIL reset_psum got %0h exp 0", bus.psum_out); end
      n_tests++; if (bus.psum_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_pv got %b exp 0", bus.psum_valid_out); end
      n_tests++; if ({bus.act_out, bus.act_valid_out} !== 17'd0) begin n_fail++; $display("FAIL reset_act got %0h/%b exp 0/0", bus.act_out, bus.act_valid_out); end
      n_tests++; if ({bus.busy, bus.repaired} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b%b exp 00", bus.busy, bus.repaired); end
      n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
      rst = 1'b1;
   endtask

   task automatic test_pass();
      drive(MODE_PASS, 1'b0, 0, 32'd0);
      load_weight(3);
      drive(MODE_PASS, 1'b1, 5, 32'd100);
      step();
      n_tests++; if (bus.psum_out !== 32'd115) begin n_fail++; $display("FAIL pass_psum got %0d exp 115", bus.psum_out); end
      n_tests++; if (bus.psum_valid_out !== 1'b1) begin n_fail++; $display("FAIL pass_pv got %b exp 1", bus.psum_valid_out); end
      n_tests++; if ({bus.act_out, bus.act_valid_out} !== {16'd5, 1'b1}) begin n_fail++; $display("FAIL pass_act got %0d/%b exp 5/1", bus.act_out, bus.act_valid_out); end
      drive(MODE_PASS, 1'b0, 7, 32'd999);
      step();
      n_tests++; if ({bus.psum_out, bus.psum_valid_out} !== {32'd115, 1'b0}) begin n_fail++; $display("FAIL pass_hold got %0d/%b exp 115/0", bus.psum_out, bus.psum_valid_out); end
      n_tests++; if ({bus.act_out, bus.act_valid_out} !== {16'd7, 1'b0}) begin n_fail++; $display("FAIL pass_act_inv got %0d/%b exp 7/0", bus.act_out, bus.act_valid_out); end
      drive(MODE_PASS, 1'b1, -4, 32'd10);
      step();
      n_tests++; if (bus.psum_out !== -32'sd2) begin n_fail++; $display("FAIL pass_neg got %0d exp -2", bus.psum_out); end
   endtask

   task automatic test_sat();
      load_weight(16);
      drive(MODE_PASS, 1'b1, 16, 32'h7FFF_FFF0);
      step();
      n_tests++; if (bus.psum_out !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_pos got %0h exp 7fffffff", bus.psum_out); end
      n_tests++; if (bus0.psum_out !== 32'h8000_00F0) begin n_fail++; $display("FAIL wrap_pos got %0h exp 800000f0", bus0.psum_out); end
      drive(MODE_PASS, 1'b1, -16, 32'h8000_0010);
      step();
      n_tests++; if (bus.psum_out !== 32'h8000_0000) begin n_fail++; $display("FAIL sat_neg got %0h exp 80000000", bus.psum_out); end
      n_tests++; if (bus0.psum_out !== 32'h7FFF_FF10) begin n_fail++; $display("FAIL wrap_neg got %0h exp 7fffff10", bus0.psum_out); end
   endtask

   task automatic test_accum();
      int   acts [18] = '{1, 2, 0, 3, 4, 5, 0, 6, 7, 8, 9, 1, 1, 1, 1, 1, 1, 1};
      logic vld  [18] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
      logic exp_pv;
      drive(MODE_ACCUM, 1'b0, 0, 32'd0);
      load_weight(2);
      for (int i = 0; i < 18; i++) begin
         drive(MODE_ACCUM, vld[i], acts[i], 32'd555);
         step();
         exp_pv = (i == 9) || (i == 17);
         n_tests++; if (bus.psum_valid_out !== exp_pv) begin n_fail++; $display("FAIL accum_pv[%0d] got %b exp %b", i, bus.psum_valid_out, exp_pv); end
         n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL accum_busy[%0d] got %b exp 1", i, bus.busy); end
         if (exp_pv) begin
            n_tests++; if (bus.psum_out !== ((i == 9) ? 32'd72 : 32'd32)) begin n_fail++; $display("FAIL accum_sum[%0d] got %0d exp %0d", i, bus.psum_out, (i == 9) ? 72 : 32); end
         end
      end
      drive(MODE_ACCUM, 1'b0, 0, 32'd0);
      step();
      n_tests++; if ({bus.psum_valid_out, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL accum_done got pv=%b busy=%b exp 0/0", bus.psum_valid_out, bus.busy); end
      n_tests++; if (bus.psum_out !== 32'd32) begin n_fail++; $display("FAIL accum_hold got %0d exp 32", bus.psum_out); end
      n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL accum_state got %0d exp 0", dbg_state); end
   endtask

   task automatic test_mode_change();
      for (int i = 0; i < 5; i++) begin
         drive(MODE_ACCUM, 1'b1, 1, 32'd0);
         step();
      end
      n_tests++; if ({bus.busy, dbg_state} !== {1'b1, ST_RUN}) begin n_fail++; $display("FAIL mc_run got busy=%b st=%0d exp 1/1", bus.busy, dbg_state); end
      drive(MODE_PASS, 1'b1, 3, 32'd7);
      step();
      n_tests++; if ({bus.psum_out, bus.psum_valid_out} !== {32'd13, 1'b1}) begin n_fail++; $display("FAIL mc_pass got %0d/%b exp 13/1", bus.psum_out, bus.psum_valid_out); end
      n_tests++; if ({bus.busy, dbg_state} !== {1'b0, ST_IDLE}) begin n_fail++; $display("FAIL mc_idle got busy=%b st=%0d exp 0/0", bus.busy, dbg_state); end
      for (int i = 0; i < 8; i++) begin
         drive(MODE_ACCUM, 1'b1, 1, 32'd0);
         step();
         n_tests++; if (bus.psum_valid_out !== (i == 7)) begin n_fail++; $display("FAIL mc_rerun_pv[%0d] got %b exp %b", i, bus.psum_valid_out, i == 7); end
      end
      n_tests++; if (bus.psum_out !== 32'd16) begin n_fail++; $display("FAIL mc_rerun_sum got %0d exp 16", bus.psum_out); end
      drive(MODE_ACCUM, 1'b0, 0, 32'd0);
      step();
   endtask

   task automatic test_weight_reset();
      bus.weight_en = 1'b1;
      bus.weight_in = 16'd5;
      drive(MODE_PASS, 1'b1, 3, 32'd0);
      step();
      bus.weight_en = 1'b0;
      n_tests++; if (bus.psum_out !== 32'd6) begin n_fail++; $display("FAIL wt_old got %0d exp 6", bus.psum_out); end
      drive(MODE_PASS, 1'b1, 3, 32'd0);
      step();
      n_tests++; if (bus.psum_out !== 32'd15) begin n_fail++; $display("FAIL wt_new got %0d exp 15", bus.psum_out); end
      for (int i = 0; i < 3; i++) begin
         drive(MODE_ACCUM, 1'b1, 2, 32'd0);
         step();
      end
      rst = 1'b0;
      drive(MODE_ACCUM, 1'b1, 2, 32'd0);
      step();
      rst = 1'b1;
      n_tests++; if ({bus.psum_out, bus.psum_valid_out, bus.act_out, bus.act_valid_out} !== 50'd0) begin n_fail++; $display("FAIL rst_mid_out got %0h/%b/%0h/%b exp 0", bus.psum_out, bus.psum_valid_out, bus.act_out, bus.act_valid_out); end
      n_tests++; if ({bus.busy, dbg_state} !== {1'b0, ST_IDLE}) begin n_fail++; $display("FAIL rst_mid_state got busy=%b st=%0d exp 0/0", bus.busy, dbg_state); end
      drive(MODE_PASS, 1'b1, 3, 32'd4);
      step();
      n_tests++; if (bus.psum_out !== 32'd4) begin n_fail++; $display("FAIL rst_weight got %0d exp 4", bus.psum_out); end
   endtask

   task automatic test_repair();
      load_weight(3);
      bus.begin_repair = 1'b1;
      drive(MODE_PASS, 1'b1, 5, 32'h1234);
      step();
      bus.begin_repair = 1'b0;
      n_tests++; if ({bus.psum_out, bus.repaired} !== {32'h1243, 1'b1}) begin n_fail++; $display("FAIL rep_pulse got %0h/%b exp 1243/1", bus.psum_out, bus.repaired); end
      drive(MODE_PASS, 1'b1, 5, 32'h1234);
      step();
      n_tests++; if ({bus.psum_out, bus.psum_valid_out} !== {32'h1234, 1'b1}) begin n_fail++; $display("FAIL rep_bypass got %0h/%b exp 1234/1", bus.psum_out, bus.psum_valid_out); end
      drive(MODE_ACCUM, 1'b0, 9, 32'h55);
      step();
      n_tests++; if ({bus.psum_out, bus.psum_valid_out, bus.busy} !== {32'h55, 2'b00}) begin n_fail++; $display("FAIL rep_accum got %0h/%b/%b exp 55/0/0", bus.psum_out, bus.psum_valid_out, bus.busy); end
      n_tests++; if (bus.act_out !== 16'd9) begin n_fail++; $display("FAIL rep_act got %0d exp 9", bus.act_out); end
      drive(MODE_RSVD, 1'b1, 2, 32'h66);
      step();
      n_tests++; if ({bus.psum_out, bus.psum_valid_out} !== {32'h66, 1'b1}) begin n_fail++; $display("FAIL rep_rsvd got %0h/%b exp 66/1", bus.psum_out, bus.psum_valid_out); end
      rst = 1'b0;
      step();
      rst = 1'b1;
      n_tests++; if (bus.repaired !== 1'b0) begin n_fail++; $display("FAIL rep_clear got %b exp 0", bus.repaired); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bus.begin_repair = 1'b0;
      bus.weight_en    = 1'b0;
      bus.weight_in    = '0;
      drive(MODE_PASS, 1'b0, 0, 32'd0);
      test_reset();
      test_pass();
      test_sat();
      test_accum();
      test_mode_change();
      test_weight_reset();
      test_repair();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
